tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
Multi-channel programmable tick generator, the parametrised successor of the fixed-divisor tick divider.
- Each of NUM_CH channels emits a one-cycle tick pulse every N clk cycles.
- N is runtime-writable per channel, applied glitch-free at the next wrap.
- Each channel runs in periodic or one-shot (retriggerable) mode.
- Feeds display multiplexing, debouncers and timeouts in the lab designs.

Parameters:
- NUM_CH, 4, number of independent channels (≥1).
- CNT_W, 32, counter/divisor width in bits.
- DEFAULT_DIV, 100_000_000, reset value of every channel's divisor; must fit in CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel enable; low pauses that channel's counter.
- mode  in  NUM_CH  per-channel mode: 0 = periodic, 1 = one-shot.
- start  in  NUM_CH  per-channel pulse: one-shot trigger / periodic phase resync.
- sync  in  1  global phase-align: clears all counters at once.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of the write.
- cfg_div  in  CNT_W  new divisor N.
- tick  out  NUM_CH  one-cycle pulse per channel, registered.
- busy  out  NUM_CH  one-shot in progress.

Behaviour:
- Reset: cnt = 0, active_div = shadow_div = DEFAULT_DIV, tick = 0, busy = 0, pending = 0, for all channels.
- Effective divisor Neff = max(active_div, 1). Neff = 1 means tick every enabled cycle.
- Periodic mode, en = 1:
  - Each edge: if cnt == Neff-1, then cnt <= 0 and tick <= 1; else cnt++ and tick <= 0.
  - First tick is high after the Neff-th enabled edge following reset; period is exactly Neff.
- en = 0: cnt and busy hold, tick <= 0. Resuming continues from the held count.
- One-shot mode:
  - start with en = 1: cnt <= 0, busy <= 1.
  - While busy, count as in periodic mode. At cnt == Neff-1: tick <= 1, busy <= 0, cnt <= 0.
  - Exactly one tick per start. Idle (busy = 0) means cnt holds at 0.
  - start while busy retriggers: cnt <= 0, no tick that cycle.
  - start with en = 0 is ignored.
- Periodic start: cnt <= 0, tick <= 0 that cycle (phase resync).
- sync: equivalent to start on every channel with en = 1; sync with mode = 1 arms the one-shot.
- Priority per channel, highest first: rst, sync/start, wrap, increment. A start/sync coinciding with a wrap suppresses that tick.
- Mode change (mode bit differs from its registered copy): cnt <= 0, busy <= 0, tick <= 0 that cycle.
- Divisor write (cfg_we = 1): shadow_div[cfg_ch] <= cfg_div, pending <= 1.
  - pending is copied to active_div at the channel's next wrap, start, sync, or while the channel is idle (en = 0, or one-shot with busy = 0).
  - A write in the same cycle as one of those events is applied immediately, via bypass of cfg_div.
  - A write while cnt ≥ new N never stalls, because the old divisor stays active until the wrap.
  - cfg_ch ≥ NUM_CH: write ignored.
- Widths: cnt is CNT_W bits, compared against Neff-1 computed in CNT_W bits. No wrap past 2^CNT_W-1.

Decomposition:
- Package tick_gen_pkg:
  - typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} tick_mode_e
  - localparam CNT_W_DEF
  - helper function eff_div(div), which returns max(div, 1).
- Sub-module tick_gen_ch: a single channel holding cnt, active/shadow divisor, pending, busy and tick.
- The top generates NUM_CH instances and decodes cfg_ch into per-channel write enables.

Test Plan:
Bench uses NUM_CH = 2, CNT_W = 8, DEFAULT_DIV = 4.
1. Reset release, en = 01, mode = 00 → tick[0] high one cycle at edges 4, 8, 12; tick[1] stays 0; busy = 00.
2. Write cfg_div = 2 to ch0 at cnt = 1 → period stays 4 until the next wrap, then ticks every 2 cycles. Write cfg_div = 0 → tick[0] high every cycle.
3. ch1 mode = 1, en = 1, start pulse → busy[1] = 1 for 4 cycles, single tick[1] at the 4th edge, busy[1] falls with it; no further ticks. Retrigger at cycle 2 → tick at cycle 6.
4. Periodic ch0 with start asserted exactly on the wrap edge → no tick that cycle, next tick 4 cycles later. en low for 3 cycles mid-count → tick delayed by exactly 3 cycles.
5. Both channels with different phases, sync pulse → subsequent ticks of equal-divisor channels coincide cycle-for-cycle.
6. rst asserted asynchronously mid-count (between edges) → tick and busy drop immediately; active_div returns to 4 even after a pending write.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package tick_gen_pkg;

  typedef enum logic {MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1} tick_mode_e;

  localparam int CNT_W_DEF = 32;
  // Widest counter the helper supports; callers cast in and out.
  localparam int DIV_MAX_W = 64;

  function automatic logic [DIV_MAX_W-1:0] eff_div(input logic [DIV_MAX_W-1:0] div);
    return (div == '0) ? DIV_MAX_W'(1) : div;
  endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: counter, active/shadow divisor with deferred update, one-shot state.
module tick_gen_ch
  import tick_gen_pkg::*;
#(
  parameter int              CNT_W       = CNT_W_DEF,
  parameter longint unsigned DEFAULT_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  tick_mode_e       mode,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             tick,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] active_div_reg;
  logic [CNT_W-1:0] shadow_div_reg;
  logic             pending_reg;
  logic             busy_reg;
  logic             tick_reg;
  tick_mode_e       mode_reg;

  logic [CNT_W-1:0] last_cnt;
  logic             mode_chg;
  logic             restart;
  logic             counting;
  logic             wrap;
  logic             idle;
  logic             apply_div;

  assign last_cnt  = CNT_W'(eff_div(DIV_MAX_W'(active_div_reg))) - CNT_W'(1);
  assign mode_chg  = (mode != mode_reg);
  assign restart   = en && !mode_chg && start;
  assign counting  = en && !mode_chg && !start && ((mode_reg == MODE_PERIODIC) || busy_reg);
  assign wrap      = counting && (cnt_reg == last_cnt);
  assign idle      = !en || ((mode_reg == MODE_ONESHOT) && !busy_reg);
  // Divisor changes only land on a boundary so a running period is never cut short.
  assign apply_div = wrap || restart || idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_div_reg <= CNT_W'(DEFAULT_DIV);
      shadow_div_reg <= CNT_W'(DEFAULT_DIV);
      pending_reg    <= 1'b0;
    end else begin
      if (cfg_we)
        shadow_div_reg <= cfg_div;
      if (apply_div) begin
        if (cfg_we)
          active_div_reg <= cfg_div;
        else if (pending_reg)
          active_div_reg <= shadow_div_reg;
        pending_reg <= 1'b0;
      end else if (cfg_we) begin
        pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      tick_reg <= 1'b0;
      mode_reg <= MODE_PERIODIC;
    end else begin
      mode_reg <= mode;
      if (mode_chg) begin
        cnt_reg  <= '0;
        busy_reg <= 1'b0;
        tick_reg <= 1'b0;
      end else if (!en) begin
        tick_reg <= 1'b0;
      end else if (start) begin
        cnt_reg  <= '0;
        busy_reg <= (mode_reg == MODE_ONESHOT);
        tick_reg <= 1'b0;
      end else if (wrap) begin
        cnt_reg  <= '0;
        busy_reg <= 1'b0;
        tick_reg <= 1'b1;
      end else if (counting) begin
        cnt_reg  <= cnt_reg + CNT_W'(1);
        tick_reg <= 1'b0;
      end else begin
        cnt_reg  <= '0;
        tick_reg <= 1'b0;
      end
    end
  end

  assign tick = tick_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator; decodes divisor writes per channel.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              CNT_W       = CNT_W_DEF,
  parameter longint unsigned DEFAULT_DIV = 100_000_000,
  localparam int             CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0] start,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic       ch_we;
      tick_mode_e ch_mode;

      // Out-of-range channel numbers match no instance and are dropped.
      assign ch_we   = cfg_we && (cfg_ch == CH_W'(gi));
      assign ch_mode = tick_mode_e'(mode[gi]);

      tick_gen_ch #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .en      (en[gi]),
        .mode    (ch_mode),
        .start   (start[gi] | sync),
        .cfg_we  (ch_we),
        .cfg_div (cfg_div),
        .tick    (tick[gi]),
        .busy    (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed self-checking bench for tick_gen_multi (2 channels, 8-bit, default divisor 4).
module tb_tick_gen_multi;

  logic       clk;
  logic       rst;
  logic [1:0] en;
  logic [1:0] mode;
  logic [1:0] start;
  logic       sync;
  logic       cfg_we;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [1:0] tick;
  logic [1:0] busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  tick_gen_multi #(
    .NUM_CH      (2),
    .CNT_W       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .start   (start),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .tick    (tick),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; mode = '0; start = '0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    repeat (2) edge1();
    chk_cnt++;
    if (tick !== 2'b00) $display("FAIL reset_tick: got %b want 00", tick);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 2'b00) $display("FAIL reset_busy: got %b want 00", busy);
    else pass_cnt++;
    rst = 1'b0;
    en  = 2'b01;
  endtask

  task automatic test_periodic();
    logic [11:0] t0;
    logic        t1_any;
    logic        b_any;
    t0 = '0; t1_any = 1'b0; b_any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edge1();
      t0[i]  = tick[0];
      t1_any = t1_any | tick[1];
      b_any  = b_any | (|busy);
    end
    chk_cnt++;
    if (t0 !== 12'b1000_1000_1000) $display("FAIL periodic_tick0: got %b want 100010001000", t0);
    else pass_cnt++;
    chk_cnt++;
    if (t1_any !== 1'b0) $display("FAIL periodic_tick1_idle: got %b want 0", t1_any);
    else pass_cnt++;
    chk_cnt++;
    if (b_any !== 1'b0) $display("FAIL periodic_busy: got %b want 0", b_any);
    else pass_cnt++;
    $display("periodic: tick0 pattern %b", t0);
  endtask

  task automatic test_divisor_write();
    logic [9:0] t0a;
    logic [5:0] t0b;
    edge1();  // ch0 now at cnt 1
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd2;
    t0a = '0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      cfg_we = 1'b0;
      t0a[i] = tick[0];
    end
    chk_cnt++;
    if (t0a !== 10'b01_0101_0100) $display("FAIL div2_deferred: got %b want 0101010100", t0a);
    else pass_cnt++;
    $display("div write 2: tick0 pattern %b", t0a);

    cfg_we = 1'b1; cfg_div = 8'd0;
    t0b = '0;
    for (int i = 0; i < 6; i++) begin
      edge1();
      cfg_we = 1'b0;
      t0b[i] = tick[0];
    end
    chk_cnt++;
    if (t0b !== 6'b111111) $display("FAIL div0_every_cycle: got %b want 111111", t0b);
    else pass_cnt++;
    $display("div write 0: tick0 pattern %b", t0b);

    // Restore divisor 4; with Neff = 1 every edge is a wrap, so it lands at once.
    cfg_we = 1'b1; cfg_div = 8'd4;
    edge1();
    cfg_we = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] t1a, b1a;
    logic [9:0] t1b, b1b;
    en = 2'b00; mode = 2'b10;
    edge1();
    en = 2'b10; start = 2'b10;
    t1a = '0; b1a = '0;
    for (int i = 0; i < 8; i++) begin
      edge1();
      start  = 2'b00;
      t1a[i] = tick[1];
      b1a[i] = busy[1];
    end
    chk_cnt++;
    if (t1a !== 8'b0001_0000) $display("FAIL oneshot_tick: got %b want 00010000", t1a);
    else pass_cnt++;
    chk_cnt++;
    if (b1a !== 8'b0000_1111) $display("FAIL oneshot_busy: got %b want 00001111", b1a);
    else pass_cnt++;
    $display("oneshot: tick1 %b busy1 %b", t1a, b1a);

    start = 2'b10;
    t1b = '0; b1b = '0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      start  = (i == 1) ? 2'b10 : 2'b00;
      t1b[i] = tick[1];
      b1b[i] = busy[1];
    end
    chk_cnt++;
    if (t1b !== 10'b00_0100_0000) $display("FAIL retrigger_tick: got %b want 0001000000", t1b);
    else pass_cnt++;
    chk_cnt++;
    if (b1b !== 10'b00_0011_1111) $display("FAIL retrigger_busy: got %b want 0000111111", b1b);
    else pass_cnt++;
    $display("retrigger: tick1 %b busy1 %b", t1b, b1b);
  endtask

  task automatic test_start_pause();
    logic [9:0] t0a;
    logic [7:0] t0b;
    en = 2'b01;
    t0a = '0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3) ? 2'b01 : 2'b00;
      edge1();
      t0a[i] = tick[0];
    end
    start = 2'b00;
    chk_cnt++;
    if (t0a !== 10'b00_1000_0000) $display("FAIL start_on_wrap: got %b want 0010000000", t0a);
    else pass_cnt++;
    $display("start on wrap: tick0 %b", t0a);

    t0b = '0;
    for (int i = 0; i < 8; i++) begin
      en = (i < 3) ? 2'b00 : 2'b01;
      edge1();
      t0b[i] = tick[0];
    end
    chk_cnt++;
    if (t0b !== 8'b0001_0000) $display("FAIL pause_delay: got %b want 00010000", t0b);
    else pass_cnt++;
    $display("pause 3 cycles: tick0 %b", t0b);
  endtask

  task automatic test_sync();
    logic [8:0] t0, t1;
    logic       pre_tick;
    mode = 2'b00; en = 2'b10;
    repeat (2) edge1();
    en = 2'b11;
    edge1();
    pre_tick = tick[0] & ~tick[1];
    chk_cnt++;
    if (pre_tick !== 1'b1) $display("FAIL sync_pre_phase: got tick %b want 01", tick);
    else pass_cnt++;
    sync = 1'b1;
    t0 = '0; t1 = '0;
    for (int i = 0; i < 9; i++) begin
      edge1();
      sync  = 1'b0;
      t0[i] = tick[0];
      t1[i] = tick[1];
    end
    chk_cnt++;
    if (t0 !== 9'b1_0001_0000) $display("FAIL sync_tick0: got %b want 100010000", t0);
    else pass_cnt++;
    chk_cnt++;
    if (t1 !== 9'b1_0001_0000) $display("FAIL sync_tick1: got %b want 100010000", t1);
    else pass_cnt++;
    $display("sync: tick0 %b tick1 %b", t0, t1);
  endtask

  task automatic test_async_reset();
    logic [5:0] t1;
    mode = 2'b10; en = 2'b11;
    edge1();
    start = 2'b10;
    edge1();
    start = 2'b00;
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd2;
    edge1();
    cfg_we = 1'b0;
    edge1();
    chk_cnt++;
    if ({tick[0], busy[1]} !== 2'b11) $display("FAIL prereset_state: got tick %b busy %b want tick0=1 busy1=1", tick, busy);
    else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({tick, busy} !== 4'b0000) $display("FAIL async_reset_drop: got tick %b busy %b want 00 00", tick, busy);
    else pass_cnt++;
    en = 2'b00; mode = 2'b10;
    edge1();
    rst = 1'b0;
    edge1();  // registers the one-shot mode on ch1
    en = 2'b10; start = 2'b10;
    t1 = '0;
    for (int i = 0; i < 6; i++) begin
      edge1();
      start = 2'b00;
      t1[i] = tick[1];
    end
    chk_cnt++;
    if (t1 !== 6'b01_0000) $display("FAIL reset_default_div: got %b want 010000", t1);
    else pass_cnt++;
    $display("after reset: tick1 %b", t1);
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_divisor_write();
    test_oneshot();
    test_start_pause();
    test_sync();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
